// File: rtl/sample_flow_engine_if.sv
// Sample-in / result-out handshake bundle for sample_flow_engine.
interface sample_flow_engine_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sample_flow_engine.sv
// Handshaked sample-flow recurrence: A <= (A >> DIV_SHIFT) + x + (A >> SQ_SHIFT)^2,
// squaring done by a serial shift-add multiplier; wrap, saturate or seed-load per sample.
module sample_flow_engine #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV_SHIFT = 2,
    parameter int unsigned SQ_SHIFT  = 3,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    sample_flow_engine_if.slave bus,
    output logic               ovf_sticky,
    input  logic               clr_ovf,
    output logic [COUNT_W-1:0] step_count
);
    localparam int unsigned WQ    = WIDTH - SQ_SHIFT;
    localparam int unsigned PW    = 2 * WQ;
    localparam int unsigned SUM_W = 2 * WIDTH + 1;
    localparam int unsigned BIT_W = $clog2(WQ + 1);

    typedef enum logic [1:0] {IDLE, MUL, ADD, OUT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   x_q;
    logic [1:0]         mode_q;
    logic [PW-1:0]      mcand_q;
    logic [WQ-1:0]      mplier_q;
    logic [PW-1:0]      prod_q;
    logic [BIT_W-1:0]   bit_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic               ovf_q;
    logic [COUNT_W-1:0] cnt_q;

    logic [SUM_W-1:0]   sum;
    logic               sum_ovf;
    logic               is_load;
    logic               step_ovf;
    logic [WIDTH-1:0]   a_next;

    // Next-state and the single-cycle ADD datapath
    always_comb begin
        state_d  = state_q;
        is_load  = (mode_q == 2'b10);
        sum      = SUM_W'(a_q >> DIV_SHIFT) + SUM_W'(x_q) + SUM_W'(prod_q);
        sum_ovf  = |sum[SUM_W-1:WIDTH];
        step_ovf = sum_ovf && !is_load;
        a_next   = sum[WIDTH-1:0];
        if (is_load) begin
            a_next = x_q;
        end else if (mode_q == 2'b01 && sum_ovf) begin
            a_next = '1;
        end

        case (state_q)
            IDLE: if (bus.in_valid) state_d = (bus.mode == 2'b10) ? ADD : MUL;
            MUL:  if (bit_q == BIT_W'(WQ - 1)) state_d = ADD;
            ADD:  state_d = OUT;
            OUT:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            x_q         <= '0;
            mode_q      <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            bit_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == OUT);

            if (state_q == IDLE && bus.in_valid) begin
                x_q      <= bus.in_data;
                mode_q   <= bus.mode;
                mcand_q  <= PW'(WQ'(a_q >> SQ_SHIFT));
                mplier_q <= WQ'(a_q >> SQ_SHIFT);
                prod_q   <= '0;
                bit_q    <= '0;
            end

            // One multiplier bit per cycle, LSB first
            if (state_q == MUL) begin
                if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                bit_q    <= bit_q + BIT_W'(1);
            end

            if (state_q == ADD) begin
                a_q        <= a_next;
                out_data_q <= a_next;
                cnt_q      <= cnt_q + COUNT_W'(1);
            end

            // A same-cycle overflow beats the clear
            if (state_q == ADD && step_ovf) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign ovf_sticky    = ovf_q;
    assign step_count    = cnt_q;
endmodule

// File: tb/tb_sample_flow_engine.sv
// Directed bench for sample_flow_engine: default 8-bit instance plus a 12-bit instance.
module tb_sample_flow_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic        clr8, clr12;
    logic        ovf8, ovf12;
    logic [15:0] cnt8, cnt12;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    sample_flow_engine_if #(.WIDTH(8))  b8 ();
    sample_flow_engine_if #(.WIDTH(12)) b12 ();

    sample_flow_engine #(.WIDTH(8), .DIV_SHIFT(2), .SQ_SHIFT(3), .COUNT_W(16)) dut8 (
        .clk(clk), .reset(reset), .bus(b8), .ovf_sticky(ovf8), .clr_ovf(clr8), .step_count(cnt8)
    );

    sample_flow_engine #(.WIDTH(12), .DIV_SHIFT(1), .SQ_SHIFT(4), .COUNT_W(16)) dut12 (
        .clk(clk), .reset(reset), .bus(b12), .ovf_sticky(ovf12), .clr_ovf(clr12), .step_count(cnt12)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one sample to the 8-bit engine, measure latency, check result and hand-off
    task automatic step8(input string tag, input logic [1:0] m, input logic [7:0] x,
                         input logic [7:0] exp_d, input int exp_lat);
        int lat = 0;
        chk({tag, "_in_ready"}, 32'(b8.in_ready), 32'd1);
        b8.in_valid = 1'b1;
        b8.in_data  = x;
        b8.mode     = m;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        b8.in_data  = 8'hFF;
        b8.mode     = 2'b10;
        while (!b8.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_out_valid"}, 32'(b8.out_valid), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_out_data"}, 32'(b8.out_data), 32'(exp_d));
        if (b8.out_ready) begin
            @(posedge clk); #1;
            chk({tag, "_post_valid"}, 32'(b8.out_valid), 32'd0);
            chk({tag, "_post_ready"}, 32'(b8.in_ready), 32'd1);
            chk({tag, "_retained"}, 32'(b8.out_data), 32'(exp_d));
        end
    endtask

    initial begin
        reset = 1'b1;
        clr8 = 1'b0;
        clr12 = 1'b0;
        b8.in_valid = 1'b0; b8.in_data = '0; b8.mode = 2'b00; b8.out_ready = 1'b1;
        b12.in_valid = 1'b0; b12.in_data = '0; b12.mode = 2'b00; b12.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(b8.in_ready), 32'd1);
        chk("rst_out_valid", 32'(b8.out_valid), 32'd0);
        chk("rst_out_data", 32'(b8.out_data), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        chk("rst_count", 32'(cnt8), 32'd0);
        reset = 1'b0;

        // Wrap-mode warm-up: 0 -> 5 -> 6 -> 101 -> 25+144=169
        step8("w5a", 2'b00, 8'd5, 8'd5, 6);
        step8("w5b", 2'b00, 8'd5, 8'd6, 6);
        step8("w100", 2'b00, 8'd100, 8'd101, 6);
        step8("w0", 2'b00, 8'd0, 8'd169, 6);
        chk("warm_ovf", 32'(ovf8), 32'd0);
        chk("warm_count", 32'(cnt8), 32'd4);

        // 42 + 21^2 = 483 -> wraps to 227
        step8("wrap_ovf", 2'b00, 8'd0, 8'd227, 6);
        chk("wrap_ovf_flag", 32'(ovf8), 32'd1);

        step8("ld169", 2'b10, 8'd169, 8'd169, 1);
        clr8 = 1'b1;
        @(posedge clk); #1;
        clr8 = 1'b0;
        chk("clr_ovf_idle", 32'(ovf8), 32'd0);
        step8("sat", 2'b01, 8'd0, 8'd255, 6);
        chk("sat_ovf_flag", 32'(ovf8), 32'd1);
        chk("sat_count", 32'(cnt8), 32'd7);

        clr8 = 1'b1;
        @(posedge clk); #1;
        clr8 = 1'b0;
        step8("ld200", 2'b10, 8'd200, 8'd200, 1);
        chk("ld_ovf_unchanged", 32'(ovf8), 32'd0);
        chk("ld_count", 32'(cnt8), 32'd8);
        // 50 + 25^2 = 675 -> 163
        step8("after_ld", 2'b00, 8'd0, 8'd163, 6);
        chk("after_ld_ovf", 32'(ovf8), 32'd1);
        chk("after_ld_count", 32'(cnt8), 32'd9);

        // Backpressure: 40 + 1 + 20^2 = 441 -> 185, result held while out_ready=0
        clr8 = 1'b1;
        @(posedge clk); #1;
        clr8 = 1'b0;
        b8.out_ready = 1'b0;
        step8("bp", 2'b00, 8'd1, 8'd185, 6);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                b8.in_valid = 1'b1;
                b8.in_data  = 8'd50;
                b8.mode     = 2'b10;
            end
            if (i == 7) b8.in_valid = 1'b0;
            @(posedge clk); #1;
            chk("bp_valid", 32'(b8.out_valid), 32'd1);
            chk("bp_data", 32'(b8.out_data), 32'd185);
            chk("bp_in_ready", 32'(b8.in_ready), 32'd0);
        end
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(b8.out_valid), 32'd0);
        chk("bp_release_ready", 32'(b8.in_ready), 32'd1);
        chk("bp_count", 32'(cnt8), 32'd10);
        chk("bp_ovf", 32'(ovf8), 32'd1);
        // Ignored offer must not have loaded 50: 46 + 23^2 = 575 -> 63
        step8("after_bp", 2'b00, 8'd0, 8'd63, 6);
        chk("after_bp_count", 32'(cnt8), 32'd11);

        // Reset in the second multiply cycle
        b8.in_valid = 1'b1;
        b8.in_data  = 8'd3;
        b8.mode     = 2'b00;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_valid", 32'(b8.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(b8.in_ready), 32'd1);
        chk("midrst_data", 32'(b8.out_data), 32'd0);
        chk("midrst_count", 32'(cnt8), 32'd0);
        chk("midrst_ovf", 32'(ovf8), 32'd0);
        step8("post_rst", 2'b00, 8'd7, 8'd7, 6);
        chk("post_rst_count", 32'(cnt8), 32'd1);

        // 12-bit instance: seed 4000, then x=10 -> 2000 + 10 + 250^2 = 64510 mod 4096 = 3070
        b12.in_valid = 1'b1;
        b12.in_data  = 12'd4000;
        b12.mode     = 2'b10;
        @(posedge clk); #1;
        b12.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("w12_ld_valid", 32'(b12.out_valid), 32'd1);
        chk("w12_ld_data", 32'(b12.out_data), 32'd4000);
        @(posedge clk); #1;
        chk("w12_ld_in_ready", 32'(b12.in_ready), 32'd1);
        b12.in_valid = 1'b1;
        b12.in_data  = 12'd10;
        b12.mode     = 2'b00;
        @(posedge clk); #1;
        b12.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        clr12 = 1'b1;
        @(posedge clk); #1;
        clr12 = 1'b0;
        chk("w12_valid", 32'(b12.out_valid), 32'd1);
        chk("w12_data", 32'(b12.out_data), 32'd3070);
        chk("w12_ovf_set_wins", 32'(ovf12), 32'd1);
        @(posedge clk); #1;
        clr12 = 1'b1;
        @(posedge clk); #1;
        clr12 = 1'b0;
        chk("w12_ovf_cleared", 32'(ovf12), 32'd0);
        chk("w12_count", 32'(cnt12), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
